// File: rtl/spart_pkg.sv
// spart_pkg: shared constants and types for the SPART peripheral.
//   - ioaddr decode values for the processor-side bus
//   - oversampling / bit-count constants for the 8N1 serial engine
//   - TX and RX state-machine encodings
package spart_pkg;

  typedef logic [1:0] ioaddr_t;

  localparam ioaddr_t ADDR_BUF    = 2'b00;
  localparam ioaddr_t ADDR_STATUS = 2'b01;
  localparam ioaddr_t ADDR_DB_LO  = 2'b10;
  localparam ioaddr_t ADDR_DB_HI  = 2'b11;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;
  localparam int DATA_BITS  = 8;

  // Sized forms of the constants above, matched to the tick/bit counters.
  localparam logic [4:0] TICK_BIT  = 5'(OVERSAMPLE);
  localparam logic [4:0] TICK_LAST = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] TICK_MID  = 5'(MID_SAMPLE - 1);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/spart_if.sv
// spart_if: processor-side control/status bundle of the SPART.
//   iocs   - chip select
//   iorw   - 1 = read, 0 = write
//   ioaddr - register address
//   tbr    - transmit buffer ready (from SPART)
//   rda    - receive data available (from SPART)
// The 8-bit tri-state databus is kept as a plain inout port on the SPART.
interface spart_if;
  import spart_pkg::*;

  logic    iocs;
  logic    iorw;
  ioaddr_t ioaddr;
  logic    tbr;
  logic    rda;

  modport master (output iocs, output iorw, output ioaddr, input tbr, input rda);
  modport slave  (input iocs, input iorw, input ioaddr, output tbr, output rda);

endinterface

// File: rtl/spart_baud_gen.sv
// spart_baud_gen: 16-bit down counter producing the 16x oversampling enable.
//   clk, rst - clock and synchronous active-high reset
//   divisor  - reload value (enable period is divisor+1 clocks)
//   reload   - restart the count from divisor on the next edge
//   en       - one-cycle enable while the counter sits at zero
module spart_baud_gen #(
  parameter logic [15:0] DIVISOR_RST = 16'd1301
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] divisor,
  input  logic        reload,
  output logic        en
);

  logic [15:0] cnt_reg;

  // Divisor 0 keeps the counter pinned at zero, so en is high every cycle.
  assign en = (cnt_reg == 16'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= DIVISOR_RST;
    end else if (reload || en) begin
      cnt_reg <= divisor;
    end else begin
      cnt_reg <= cnt_reg - 16'd1;
    end
  end

endmodule

// File: rtl/spart.sv
// spart: special-purpose UART answering the processor bus driver.
//   clk, rst - clock and synchronous active-high reset
//   bus      - spart_if.slave: iocs/iorw/ioaddr in, tbr/rda out
//   databus  - shared 8-bit tri-state bus, driven only during reads
//   rxd      - asynchronous serial input (idle high)
//   txd      - serial output (idle high)
// 8N1 transmitter and receiver timed by a 16x oversampling enable.
module spart
  import spart_pkg::*;
#(
  parameter logic [15:0] DIVISOR_RST = 16'd1301
) (
  input  logic       clk,
  input  logic       rst,
  spart_if.slave     bus,
  inout  wire  [7:0] databus,
  input  logic       rxd,
  output logic       txd
);

  // ---------------- bus decode ----------------
  logic        wr_cycle;
  logic        rd_cycle;
  logic        buf_wr;
  logic        buf_rd;
  logic        div_lo_wr;
  logic        div_hi_wr;
  logic [15:0] divisor_reg;
  logic [15:0] divisor_next;
  logic [7:0]  rd_data;
  logic        baud_en;

  logic        tbr_reg;
  logic        rda_reg;
  logic [7:0]  rx_buf_reg;

  assign wr_cycle  = bus.iocs && !bus.iorw;
  assign rd_cycle  = bus.iocs && bus.iorw;
  // A buffer write while a frame is in flight is dropped.
  assign buf_wr    = wr_cycle && (bus.ioaddr == ADDR_BUF) && tbr_reg;
  assign buf_rd    = rd_cycle && (bus.ioaddr == ADDR_BUF);
  assign div_lo_wr = wr_cycle && (bus.ioaddr == ADDR_DB_LO);
  assign div_hi_wr = wr_cycle && (bus.ioaddr == ADDR_DB_HI);

  always_comb begin
    divisor_next = divisor_reg;
    if (div_lo_wr) divisor_next[7:0]  = databus;
    if (div_hi_wr) divisor_next[15:8] = databus;
  end

  always_ff @(posedge clk) begin
    if (rst) divisor_reg <= DIVISOR_RST;
    else     divisor_reg <= divisor_next;
  end

  always_comb begin
    rd_data = 8'h00;
    case (bus.ioaddr)
      ADDR_BUF:    rd_data = rx_buf_reg;
      ADDR_STATUS: rd_data = {6'b0, tbr_reg, rda_reg};
      ADDR_DB_LO:  rd_data = divisor_reg[7:0];
      ADDR_DB_HI:  rd_data = divisor_reg[15:8];
      default:     rd_data = 8'h00;
    endcase
  end

  assign databus = rd_cycle ? rd_data : 8'hzz;
  assign bus.tbr = tbr_reg;
  assign bus.rda = rda_reg;

  // The counter is handed the post-write divisor so a divisor write
  // restarts timing with the new value straight away, even mid-frame.
  spart_baud_gen #(
    .DIVISOR_RST(DIVISOR_RST)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .divisor(divisor_next),
    .reload (div_lo_wr || div_hi_wr),
    .en     (baud_en)
  );

  // ---------------- transmitter ----------------
  tx_state_t  tx_state_reg;
  logic [7:0] tx_buf_reg;
  logic [4:0] tx_tick_reg;
  logic [2:0] tx_bit_reg;
  logic       txd_reg;

  assign txd = txd_reg;

  // tx_tick counts enables since the current bit went onto the line,
  // the enable that launched it counting as 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_reg <= TX_IDLE;
      tx_buf_reg   <= 8'h00;
      tx_tick_reg  <= 5'd0;
      tx_bit_reg   <= 3'd0;
      txd_reg      <= 1'b1;
      tbr_reg      <= 1'b1;
    end else begin
      case (tx_state_reg)
        TX_IDLE: begin
          if (buf_wr) begin
            tx_buf_reg   <= databus;
            tbr_reg      <= 1'b0;
            tx_tick_reg  <= 5'd0;
            tx_state_reg <= TX_START;
          end
        end
        TX_START: begin
          if (baud_en) begin
            if (tx_tick_reg == TICK_BIT) begin
              txd_reg      <= tx_buf_reg[0];
              tx_bit_reg   <= 3'd0;
              tx_tick_reg  <= 5'd1;
              tx_state_reg <= TX_DATA;
            end else begin
              txd_reg     <= 1'b0;
              tx_tick_reg <= tx_tick_reg + 5'd1;
            end
          end
        end
        TX_DATA: begin
          if (baud_en) begin
            if (tx_tick_reg == TICK_BIT) begin
              tx_tick_reg <= 5'd1;
              if (tx_bit_reg == LAST_BIT) begin
                txd_reg      <= 1'b1;
                tx_state_reg <= TX_STOP;
              end else begin
                txd_reg    <= tx_buf_reg[3'(tx_bit_reg + 3'd1)];
                tx_bit_reg <= tx_bit_reg + 3'd1;
              end
            end else begin
              tx_tick_reg <= tx_tick_reg + 5'd1;
            end
          end
        end
        TX_STOP: begin
          // 16th enable of the stop bit ends the frame.
          if (baud_en) begin
            if (tx_tick_reg == TICK_LAST) begin
              tbr_reg      <= 1'b1;
              tx_state_reg <= TX_IDLE;
            end else begin
              tx_tick_reg <= tx_tick_reg + 5'd1;
            end
          end
        end
        default: tx_state_reg <= TX_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  rx_state_t  rx_state_reg;
  logic       rxd_meta_reg;
  logic       rxd_sync_reg;
  logic       rxd_prev_reg;
  logic [4:0] rx_tick_reg;
  logic [2:0] rx_bit_reg;
  logic [7:0] rx_shift_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_reg <= 1'b1;
      rxd_sync_reg <= 1'b1;
      rxd_prev_reg <= 1'b1;
    end else begin
      rxd_meta_reg <= rxd;
      rxd_sync_reg <= rxd_meta_reg;
      rxd_prev_reg <= rxd_sync_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_reg <= RX_IDLE;
      rx_tick_reg  <= 5'd0;
      rx_bit_reg   <= 3'd0;
      rx_shift_reg <= 8'h00;
      rx_buf_reg   <= 8'h00;
      rda_reg      <= 1'b0;
    end else begin
      // A completing frame below overrides this clear.
      if (buf_rd) rda_reg <= 1'b0;
      case (rx_state_reg)
        RX_IDLE: begin
          if (rxd_prev_reg && !rxd_sync_reg) begin
            rx_tick_reg  <= 5'd0;
            rx_state_reg <= RX_START;
          end
        end
        RX_START: begin
          // Re-check the line half a bit in; a high here is a glitch.
          if (baud_en) begin
            if (rx_tick_reg == TICK_MID) begin
              rx_tick_reg  <= 5'd0;
              rx_bit_reg   <= 3'd0;
              rx_state_reg <= rxd_sync_reg ? RX_IDLE : RX_DATA;
            end else begin
              rx_tick_reg <= rx_tick_reg + 5'd1;
            end
          end
        end
        RX_DATA: begin
          if (baud_en) begin
            if (rx_tick_reg == TICK_LAST) begin
              rx_tick_reg              <= 5'd0;
              rx_shift_reg[rx_bit_reg] <= rxd_sync_reg;
              if (rx_bit_reg == LAST_BIT) rx_state_reg <= RX_STOP;
              else                        rx_bit_reg   <= rx_bit_reg + 3'd1;
            end else begin
              rx_tick_reg <= rx_tick_reg + 5'd1;
            end
          end
        end
        RX_STOP: begin
          if (baud_en) begin
            if (rx_tick_reg == TICK_LAST) begin
              rx_state_reg <= RX_IDLE;
              // Low stop bit is a framing error: byte dropped silently.
              if (rxd_sync_reg) begin
                rx_buf_reg <= rx_shift_reg;
                rda_reg    <= 1'b1;
              end
            end else begin
              rx_tick_reg <= rx_tick_reg + 5'd1;
            end
          end
        end
        default: rx_state_reg <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spart.sv
// tb_spart: self-checking bench for the SPART.
//   Table of bus reads after reset, hand sequences for multi-cycle corners,
//   and randomized loopback frames checked against a frame-level model.
module tb_spart;
  import spart_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spart_if bus();

  wire  [7:0] databus;
  logic       drv_en;
  logic [7:0] drv_data;
  assign databus = drv_en ? drv_data : 8'hzz;

  // Undriven bus reads back as 8'hFF.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_pull
      pullup (databus[gi]);
    end
  endgenerate

  logic rxd_drv;
  logic loop_en;
  logic txd;
  wire  rxd = loop_en ? txd : rxd_drv;

  spart #(.DIVISOR_RST(16'd1301)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .databus(databus),
    .rxd    (rxd),
    .txd    (txd)
  );

  int checks   = 0;
  int failures = 0;
  int period   = 1302;

  // Frame-level receive model: last good byte and its availability flag.
  logic [7:0] model_rx_buf = 8'h00;

  typedef struct {
    logic       cs;
    logic       rw;
    logic [1:0] addr;
    logic [7:0] exp;
    string      name;
  } rd_vec_t;

  rd_vec_t vecs[6];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.iocs = 1'b1; bus.iorw = 1'b0; bus.ioaddr = a;
    drv_data = d; drv_en = 1'b1;
    @(negedge clk);
    bus.iocs = 1'b0; drv_en = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = a;
    #2 d = databus;
    @(negedge clk);
    bus.iocs = 1'b0;
  endtask

  task automatic wait_txd_fall(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 2 * period + 8; i++) begin
      @(negedge clk);
      if (txd == 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Samples every bit mid-way from the start edge, then times tbr.
  task automatic check_tx_frame(input logic [7:0] b, input string tag);
    bit seen;
    int n;
    wait_txd_fall(seen);
    check({tag, "_start"}, 16'(seen), 16'd1);
    if (!seen) return;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      int tgt;
      tgt = 8 * period + 16 * period * k;
      while (n < tgt) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("%s_bit%0d", tag, k), 16'(txd), 16'(frame_bit(b, k)));
    end
    while (bus.tbr !== 1'b1 && n < 170 * period) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_tbr_time"}, 16'(n), 16'(159 * period));
  endtask

  task automatic set_divisor(input logic [15:0] d);
    bus_write(ADDR_DB_HI, d[15:8]);
    bus_write(ADDR_DB_LO, d[7:0]);
    period = int'(d) + 1;
  endtask

  // Transmit through the loopback and fold the byte into the rx model.
  task automatic send_loop(input logic [7:0] b, input string tag);
    fork
      bus_write(ADDR_BUF, b);
      check_tx_frame(b, tag);
    join
    model_rx_buf = b;
    check({tag, "_rda"}, 16'(bus.rda), 16'd1);
  endtask

  task automatic send_serial(input logic [7:0] b, input logic stop_bit);
    rxd_drv = 1'b0;
    repeat (16 * period) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rxd_drv = b[k];
      repeat (16 * period) @(negedge clk);
    end
    rxd_drv = stop_bit;
    repeat (16 * period) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (16 * period) @(negedge clk);
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] rb;
    bit         seen;
    bit         saw_low;

    vecs[0] = '{1'b1, 1'b1, ADDR_STATUS, 8'h02, "rd_status"};
    vecs[1] = '{1'b1, 1'b1, ADDR_DB_LO,  8'h15, "rd_div_lo"};
    vecs[2] = '{1'b1, 1'b1, ADDR_DB_HI,  8'h05, "rd_div_hi"};
    vecs[3] = '{1'b0, 1'b1, ADDR_STATUS, 8'hFF, "hiz_cs0"};
    vecs[4] = '{1'b1, 1'b1, ADDR_BUF,    8'h00, "rd_rxbuf"};
    vecs[5] = '{1'b1, 1'b0, ADDR_STATUS, 8'hFF, "hiz_write"};

    rst = 1'b1;
    bus.iocs = 1'b0; bus.iorw = 1'b0; bus.ioaddr = 2'b00;
    drv_en = 1'b0; drv_data = 8'h00;
    rxd_drv = 1'b1; loop_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_txd", 16'(txd), 16'd1);
    check("rst_tbr", 16'(bus.tbr), 16'd1);
    check("rst_rda", 16'(bus.rda), 16'd0);

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.iocs = vecs[i].cs; bus.iorw = vecs[i].rw; bus.ioaddr = vecs[i].addr;
      #2 check(vecs[i].name, 16'(databus), 16'(vecs[i].exp));
    end
    @(negedge clk);
    bus.iocs = 1'b0;

    // Period-2 enable, single frame of 8'hA5 with tbr handshake.
    set_divisor(16'd1);
    bus_read(ADDR_DB_LO, rb);
    check("div_lo_new", 16'(rb), 16'h01);
    fork
      begin
        bus_write(ADDR_BUF, 8'hA5);
        check("tbr_low", 16'(bus.tbr), 16'd0);
      end
      check_tx_frame(8'hA5, "tx_a5");
    join

    // Loopback receive of 8'h3C and rda clear on read.
    loop_en = 1'b1;
    send_loop(8'h3C, "lb_3c");
    bus_read(ADDR_BUF, rb);
    check("lb_3c_data", 16'(rb), 16'(model_rx_buf));
    check("lb_3c_rda_clr", 16'(bus.rda), 16'd0);

    // Randomized bytes and divisors through the loopback.
    for (int it = 0; it < 6; it++) begin
      logic [7:0] b;
      set_divisor(16'($urandom_range(0, 3)));
      b = 8'($urandom_range(0, 255));
      send_loop(b, $sformatf("rnd%0d", it));
      bus_read(ADDR_BUF, rb);
      check($sformatf("rnd%0d_data", it), 16'(rb), 16'(model_rx_buf));
      check($sformatf("rnd%0d_rda_clr", it), 16'(bus.rda), 16'd0);
    end

    // Second frame lands while rda is still set: newest byte wins.
    set_divisor(16'd1);
    send_loop(8'h81, "ovr_a");
    send_loop(8'h7E, "ovr_b");
    bus_read(ADDR_BUF, rb);
    check("ovr_data", 16'(rb), 16'(model_rx_buf));
    loop_en = 1'b0;

    // Glitch shorter than half a bit: no byte.
    rxd_drv = 1'b0;
    repeat (4 * period) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (40 * period) @(negedge clk);
    check("false_start_rda", 16'(bus.rda), 16'd0);

    // Framing error: byte dropped, buffer keeps the previous value.
    send_serial(8'h5A, 1'b0);
    check("frame_err_rda", 16'(bus.rda), 16'd0);
    bus_read(ADDR_BUF, rb);
    check("frame_err_buf", 16'(rb), 16'(model_rx_buf));

    // Receiver still healthy afterwards.
    send_serial(8'hC3, 1'b1);
    model_rx_buf = 8'hC3;
    check("good_rx_rda", 16'(bus.rda), 16'd1);
    bus_read(ADDR_BUF, rb);
    check("good_rx_data", 16'(rb), 16'(model_rx_buf));

    // Back-to-back buffer writes: the second one is dropped.
    fork
      begin
        @(negedge clk);
        bus.iocs = 1'b1; bus.iorw = 1'b0; bus.ioaddr = ADDR_BUF;
        drv_en = 1'b1; drv_data = 8'h11;
        @(negedge clk);
        drv_data = 8'h22;
        @(negedge clk);
        bus.iocs = 1'b0; drv_en = 1'b0;
      end
      check_tx_frame(8'h11, "b2b");
    join
    saw_low = 1'b0;
    for (int i = 0; i < 40 * period; i++) begin
      @(negedge clk);
      if (txd == 1'b0) saw_low = 1'b1;
    end
    check("b2b_no_second", 16'(saw_low), 16'd0);
    check("b2b_tbr", 16'(bus.tbr), 16'd1);

    // Reset in the middle of data bit 3 (0 for 8'hA5).
    fork
      bus_write(ADDR_BUF, 8'hA5);
      wait_txd_fall(seen);
    join
    check("rstmid_start", 16'(seen), 16'd1);
    repeat (8 * period + 16 * period * 4) @(negedge clk);
    check("rstmid_pre_txd", 16'(txd), 16'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_txd", 16'(txd), 16'd1);
    check("rstmid_tbr", 16'(bus.tbr), 16'd1);
    rst = 1'b0;
    bus_read(ADDR_DB_LO, d);
    check("rstmid_div_lo", 16'(d), 16'h15);
    bus_read(ADDR_DB_HI, d);
    check("rstmid_div_hi", 16'(d), 16'h05);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spart.md
# spart

Special-purpose UART (SPART) peripheral that answers the processor-side bus driver: it decodes chip-select/read-write/address cycles on the shared 8-bit tri-state databus, holds the 16-bit baud divisor, and runs an 8N1 transmitter and receiver with 16x oversampling. It sits between the driver and the board's serial pins (txd/rxd). Status flags tbr/rda are exported directly to the driver.

## Interface
- DIVISOR_RST, 16'd1301, divisor loaded at reset (4800 baud at 100 MHz, 16x)
- clk  in  1  system clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- iocs  in  1  chip select; a bus cycle occurs only when high
- iorw  in  1  1 = read (spart drives databus), 0 = write (driver drives databus)
- ioaddr  in  2  00 tx/rx buffer, 01 status, 10 divisor low byte, 11 divisor high byte
- databus  inout  8  driven by spart only when iocs && iorw, else high-Z
- rxd  in  1  serial input, asynchronous, idle high
- txd  out  1  serial output, idle high
- tbr  out  1  transmit buffer ready
- rda  out  1  receive data available

## Operation
- Writes (iocs && !iorw) sample databus on the rising edge: addr 00 loads tx buffer (ignored when tbr=0); 10/11 load divisor low/high byte and reload baud counter; 01 ignored.
- Reads (iocs && iorw) drive databus combinationally: 00 rx buffer; 01 {6'b0, tbr, rda}; 10/11 divisor low/high.
- Baud generator: 16-bit down counter loaded with divisor; emits 1-cycle enable on reaching 0, then reloads; period = divisor+1 clocks. Divisor 0 gives enable every cycle.
- TX FSM: IDLE -> START -> DATA (8 bits, LSB first) -> STOP -> IDLE. Each bit lasts 16 enables. Leaves IDLE on the cycle after a tx-buffer write.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE. rxd passes a 2-flop synchronizer. Falling edge in IDLE enters START; at 8th enable rxd re-checked: high -> false start, back to IDLE. Data bits sampled every 16 enables thereafter (mid-bit). Stop sampled high -> rx buffer written, rda=1; stop low -> framing error, byte discarded, rda unchanged.
- Reset values: txd=1, tbr=1, rda=0, rx buffer=8'h00, tx buffer=8'h00, divisor=DIVISOR_RST, both FSMs IDLE, baud counter=DIVISOR_RST, databus high-Z.

## Timing
- tbr falls the cycle after an accepted addr-00 write; txd goes low on the first enable after that; tbr rises the cycle after the stop bit's 16th enable (frame = 160 enables).
- rda rises the cycle after the stop-bit sample; falls the cycle after an addr-00 read.
- Read data valid in the same cycle as iocs && iorw (combinational); no wait states.
- Divisor write takes effect immediately: counter reloaded with new value the next cycle, mid-frame included (bit timing shifts, no frame abort).
- Simultaneous addr-00 read and rx completion: new byte wins, rda stays 1.
- rx completion while rda=1: overwrite rx buffer, rda stays 1 (no overrun flag).
- addr-00 write while tbr=0: ignored, frame in flight unaffected.
- rst mid-frame: txd=1 and both FSMs IDLE the cycle after rst is sampled; partial bytes lost.

## Structure
- Package spart_pkg: ioaddr constants (ADDR_BUF, ADDR_STATUS, ADDR_DB_LO, ADDR_DB_HI), OVERSAMPLE=16, MID_SAMPLE=8, DATA_BITS=8, FSM state enums for TX and RX.
- One sub-module: spart_baud_gen (divisor in, reload strobe in, enable out); TX/RX FSMs and bus decode stay in spart.

## Test plan
- Reset, then read addr 01 and 10/11 -> databus 8'h02 (tbr=1, rda=0), 8'h15, 8'h05; txd=1; databus high-Z when iocs=0.
- Write 8'h00 to addr 11, 8'h01 to addr 10 (period 2), write 8'hA5 to addr 00 -> tbr=0 next cycle; txd shows 0,1,0,1,0,0,1,0,1,1 each 32 clocks; tbr=1 after stop.
- Loop txd to rxd, send 8'h3C -> rda=1 after stop; read addr 00 returns 8'h3C; rda=0 next cycle.
- Drive rxd low for 4 enables then high -> no byte, rda stays 0; frame with stop bit 0 -> rda stays 0, rx buffer unchanged.
- Write 8'h11 then 8'h22 to addr 00 back-to-back -> only 8'h11 transmitted.
- Assert rst during DATA bit 3 of tx -> txd=1, tbr=1 next cycle, divisor back to 1301.
